// File: rtl/wb_regfile_pkg.sv
// Shared writeback-stage definitions: datapath sizes, zero register
// and the WB_Control bit layout carried through the MEM/WB register.
package wb_regfile_pkg;

  localparam int WB_DATA_W   = 32;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_ZERO_REG = 0;

  localparam int WB_CTRL_W        = 2;
  localparam int WB_CTRL_REGWRITE = 0;
  localparam int WB_CTRL_MEMTOREG = 1;

  // Last member is bit0, matching WB_CTRL_REGWRITE.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback value select: load data or ALU result.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data
);

  assign wb_data = mem_to_reg ? rd : alu_result;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: commits to the architectural register file,
// serves two bypassed read ports and emits a commit trace.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int ZERO_REG = WB_ZERO_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] RD,
  input  logic [DATA_W-1:0] Alu_Result,
  input  logic [ADDR_W-1:0] WR,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_reg,
  output logic [DATA_W-1:0] commit_data
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  wb_ctrl_t ctrl;
  logic [DATA_W-1:0] regs [NREGS];

  assign ctrl.reg_write  = RegWrite;
  assign ctrl.mem_to_reg = MemtoReg;

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_mux (
    .mem_to_reg(ctrl.mem_to_reg),
    .rd        (RD),
    .alu_result(Alu_Result),
    .wb_data   (wb_data)
  );

  assign wb_we = ctrl.reg_write && (WR != ZR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we) begin
      regs[WR] <= wb_data;
    end
  end

  // Gating on wb_we keeps X data out of the trace on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
    end else begin
      commit_valid <= wb_we;
      if (wb_we) begin
        commit_reg  <= WR;
        commit_data <= wb_data;
      end
    end
  end

  logic rs_zero, rs_byp;
  logic rt_zero, rt_byp;

  assign rs_zero = (rs_addr == ZR);
  assign rt_zero = (rt_addr == ZR);
  assign rs_byp  = wb_we && (rs_addr == WR);
  assign rt_byp  = wb_we && (rt_addr == WR);

  // Zero and bypass are exclusive: wb_we implies WR != ZR.
  always_comb begin
    rs_data = '0;
    unique case (1'b1)
      rs_zero: rs_data = '0;
      rs_byp:  rs_data = wb_data;
      default: rs_data = regs[rs_addr];
    endcase
  end

  always_comb begin
    rt_data = '0;
    unique case (1'b1)
      rt_zero: rt_data = '0;
      rt_byp:  rt_data = wb_data;
      default: rt_data = regs[rt_addr];
    endcase
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] RD;
  logic [31:0] Alu_Result;
  logic [4:0]  WR;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;

  int total;
  int passed;

  wb_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .RD          (RD),
    .Alu_Result  (Alu_Result),
    .WR          (WR),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .commit_valid(commit_valid),
    .commit_reg  (commit_reg),
    .commit_data (commit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rst_n      = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RD         = '0;
    Alu_Result = '0;
    WR         = '0;
    rs_addr    = 5'd5;
    rt_addr    = 5'd8;
    #1;
    check("rst_rs", rs_data, 32'h0);
    check("rst_cv", {31'b0, commit_valid}, 32'h0);
    check("rst_cr", {27'b0, commit_reg}, 32'h0);
    check("rst_cd", commit_data, 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // Write regs[5] then reset mid-stream
    RegWrite   = 1'b1;
    Alu_Result = 32'h1234;
    WR         = 5'd5;
    tick();
    RegWrite = 1'b0;
    #1;
    check("w5_rs", rs_data, 32'h1234);
    check("w5_cv", {31'b0, commit_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mrst_rs", rs_data, 32'h0);
    check("mrst_cv", {31'b0, commit_valid}, 32'h0);
    check("mrst_cd", commit_data, 32'h0);
    RegWrite   = 1'b1;
    Alu_Result = 32'h99;
    WR         = 5'd6;
    tick();
    RegWrite = 1'b0;
    rs_addr  = 5'd6;
    #1;
    check("mrst_lost", rs_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU writeback to r8
    RegWrite   = 1'b1;
    MemtoReg   = 1'b0;
    RD         = 32'h0BAD0BAD;
    Alu_Result = 32'hDEADBEEF;
    WR         = 5'd8;
    #1;
    check("alu_we", {31'b0, wb_we}, 32'h1);
    check("alu_wbd", wb_data, 32'hDEADBEEF);
    tick();
    check("alu_cv", {31'b0, commit_valid}, 32'h1);
    check("alu_cr", {27'b0, commit_reg}, 32'd8);
    check("alu_cd", commit_data, 32'hDEADBEEF);
    RegWrite = 1'b0;
    rt_addr  = 5'd8;
    #1;
    check("alu_rt", rt_data, 32'hDEADBEEF);

    // Load writeback with dual-port bypass on r3
    RegWrite   = 1'b1;
    MemtoReg   = 1'b1;
    RD         = 32'h0000CAFE;
    Alu_Result = 32'h00000001;
    WR         = 5'd3;
    rs_addr    = 5'd3;
    rt_addr    = 5'd3;
    #1;
    check("ld_wbd", wb_data, 32'h0000CAFE);
    check("ld_byp_rs", rs_data, 32'h0000CAFE);
    check("ld_byp_rt", rt_data, 32'h0000CAFE);
    tick();
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    #1;
    check("ld_arr_rs", rs_data, 32'h0000CAFE);
    check("ld_arr_rt", rt_data, 32'h0000CAFE);
    check("ld_cr", {27'b0, commit_reg}, 32'd3);

    // Write to zero register is discarded
    RegWrite   = 1'b1;
    Alu_Result = 32'hFFFFFFFF;
    WR         = 5'd0;
    rs_addr    = 5'd0;
    rt_addr    = 5'd8;
    #1;
    check("z_rs_pre", rs_data, 32'h0);
    check("z_we", {31'b0, wb_we}, 32'h0);
    tick();
    check("z_cv", {31'b0, commit_valid}, 32'h0);
    check("z_cd_hold", commit_data, 32'h0000CAFE);
    check("z_rs_post", rs_data, 32'h0);
    check("z_rt_r8", rt_data, 32'hDEADBEEF);

    // Disabled write leaves r9 alone
    Alu_Result = 32'h77;
    WR         = 5'd9;
    tick();
    RegWrite   = 1'b0;
    Alu_Result = 32'h55;
    rs_addr    = 5'd9;
    #1;
    check("dis_rs_pre", rs_data, 32'h77);
    check("dis_we", {31'b0, wb_we}, 32'h0);
    tick();
    check("dis_rs_post", rs_data, 32'h77);
    check("dis_cv", {31'b0, commit_valid}, 32'h0);
    check("dis_cd", commit_data, 32'h77);
    RD         = 'x;
    Alu_Result = 'x;
    MemtoReg   = 1'bx;
    tick();
    check("x_cd", commit_data, 32'h77);
    check("x_rs", rs_data, 32'h77);
    MemtoReg = 1'b0;

    // Back-to-back writes to r31
    RegWrite   = 1'b1;
    Alu_Result = 32'h11;
    WR         = 5'd31;
    rs_addr    = 5'd31;
    #1;
    check("b2b_byp1", rs_data, 32'h11);
    tick();
    Alu_Result = 32'h22;
    #1;
    check("b2b_byp2", rs_data, 32'h22);
    check("b2b_cd1", commit_data, 32'h11);
    tick();
    RegWrite = 1'b0;
    #1;
    check("b2b_arr", rs_data, 32'h22);
    check("b2b_cd2", commit_data, 32'h22);
    check("b2b_cr", {27'b0, commit_reg}, 32'd31);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
